// File: rtl/median_scan_engine_pkg.sv
// Shared types, widths and compare helpers for the median scan engine.
package median_scan_pkg;

  localparam int PIX_W   = 8;
  localparam int ADDR_W  = 8;
  localparam int MED_LAT = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] row;
    logic [ADDR_W-1:0] col;
  } chain_entry_t;

  function automatic logic [PIX_W-1:0] min2(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [PIX_W-1:0] max2(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b);
    return (a < b) ? b : a;
  endfunction

  function automatic logic [PIX_W-1:0] min3(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b,
                                            input logic [PIX_W-1:0] c);
    return min2(min2(a, b), c);
  endfunction

  function automatic logic [PIX_W-1:0] max3(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b,
                                            input logic [PIX_W-1:0] c);
    return max2(max2(a, b), c);
  endfunction

  // Median of three: larger of (smaller pair member, smaller of larger pair member and c).
  function automatic logic [PIX_W-1:0] med3(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b,
                                            input logic [PIX_W-1:0] c);
    return max2(min2(a, b), min2(max2(a, b), c));
  endfunction

endpackage

// File: rtl/median_scan_engine_if.sv
// Memory-side bus of the median scan engine: window read port and filtered write port.
interface median_scan_engine_if
  import median_scan_pkg::*;
();

  logic              rd;
  logic [ADDR_W-1:0] addr_row_r;
  logic [ADDR_W-1:0] addr_col_r;
  logic [PIX_W-1:0]  sw_pixel_1, sw_pixel_2, sw_pixel_3;
  logic [PIX_W-1:0]  sw_pixel_4, sw_pixel_5, sw_pixel_6;
  logic [PIX_W-1:0]  sw_pixel_7, sw_pixel_8, sw_pixel_9;
  logic              wr;
  logic [ADDR_W-1:0] addr_row_w;
  logic [ADDR_W-1:0] addr_col_w;
  logic [PIX_W-1:0]  cl_pixel;

  modport master (
    output rd, addr_row_r, addr_col_r, wr, addr_row_w, addr_col_w, cl_pixel,
    input  sw_pixel_1, sw_pixel_2, sw_pixel_3, sw_pixel_4, sw_pixel_5,
           sw_pixel_6, sw_pixel_7, sw_pixel_8, sw_pixel_9
  );

  modport slave (
    input  rd, addr_row_r, addr_col_r, wr, addr_row_w, addr_col_w, cl_pixel,
    output sw_pixel_1, sw_pixel_2, sw_pixel_3, sw_pixel_4, sw_pixel_5,
           sw_pixel_6, sw_pixel_7, sw_pixel_8, sw_pixel_9
  );

endinterface

// File: rtl/median_scan_engine_median9_pipe.sv
// Three-stage 3x3 median: row sort, column reduce, final median of three.
// MEDIAN_SCAN_PASSTHRU_EN adds a centre-pixel bypass with identical latency.
module median9_pipe
  import median_scan_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
`ifdef MEDIAN_SCAN_PASSTHRU_EN
  input  logic             passthru_i,
`endif
  input  logic [PIX_W-1:0] p1_i,
  input  logic [PIX_W-1:0] p2_i,
  input  logic [PIX_W-1:0] p3_i,
  input  logic [PIX_W-1:0] p4_i,
  input  logic [PIX_W-1:0] p5_i,
  input  logic [PIX_W-1:0] p6_i,
  input  logic [PIX_W-1:0] p7_i,
  input  logic [PIX_W-1:0] p8_i,
  input  logic [PIX_W-1:0] p9_i,
  output logic [PIX_W-1:0] median_o
);

  logic [2:0][2:0][PIX_W-1:0] win_s;
  logic [2:0][PIX_W-1:0]      min_d, med_d, max_d;
  logic [2:0][PIX_W-1:0]      min_q, med_q, max_q;
  logic [PIX_W-1:0]           lo_d, mid_d, hi_d, res_d;
  logic [PIX_W-1:0]           lo_q, mid_q, hi_q, res_q;
  logic                       v1_q, v2_q;
`ifdef MEDIAN_SCAN_PASSTHRU_EN
  logic                       pt1_q, pt2_q;
  logic [PIX_W-1:0]           c5_1_q, c5_2_q;
`endif

  // Stage 1 combinational: sort each row triple.
  always_comb begin
    win_s[0] = {p3_i, p2_i, p1_i};
    win_s[1] = {p6_i, p5_i, p4_i};
    win_s[2] = {p9_i, p8_i, p7_i};
    for (int r = 0; r < 3; r++) begin
      min_d[r] = min3(win_s[r][0], win_s[r][1], win_s[r][2]);
      med_d[r] = med3(win_s[r][0], win_s[r][1], win_s[r][2]);
      max_d[r] = max3(win_s[r][0], win_s[r][1], win_s[r][2]);
    end
  end

  // Stages 2 and 3 combinational: column reduce, then median of the three survivors.
  always_comb begin
    lo_d  = max3(min_q[0], min_q[1], min_q[2]);
    mid_d = med3(med_q[0], med_q[1], med_q[2]);
    hi_d  = min3(max_q[0], max_q[1], max_q[2]);
`ifdef MEDIAN_SCAN_PASSTHRU_EN
    if (pt2_q) begin
      res_d = c5_2_q;
    end else begin
      res_d = med3(lo_q, mid_q, hi_q);
    end
`else
    res_d = med3(lo_q, mid_q, hi_q);
`endif
  end

  // Pipeline registers; the result only updates for a valid window so it holds between writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      min_q <= '0;
      med_q <= '0;
      max_q <= '0;
      lo_q  <= '0;
      mid_q <= '0;
      hi_q  <= '0;
      res_q <= '0;
    end else begin
      v1_q  <= valid_i;
      v2_q  <= v1_q;
      min_q <= min_d;
      med_q <= med_d;
      max_q <= max_d;
      lo_q  <= lo_d;
      mid_q <= mid_d;
      hi_q  <= hi_d;
      if (v2_q) begin
        res_q <= res_d;
      end
    end
  end

`ifdef MEDIAN_SCAN_PASSTHRU_EN
  // Centre pixel and mode flag delayed alongside stages 1 and 2.
  always_ff @(posedge clk) begin
    if (rst) begin
      pt1_q  <= 1'b0;
      pt2_q  <= 1'b0;
      c5_1_q <= '0;
      c5_2_q <= '0;
    end else begin
      pt1_q  <= passthru_i;
      pt2_q  <= pt1_q;
      c5_1_q <= p5_i;
      c5_2_q <= c5_1_q;
    end
  end
`endif

  assign median_o = res_q;

endmodule

// File: rtl/median_scan_engine.sv
// Frame scanner: issues one 3x3 window read per cycle and writes back its median.
// Optional macro MEDIAN_SCAN_PASSTHRU_EN adds the passthru input (centre pixel copy).
module median_scan_engine
  import median_scan_pkg::*;
#(
  parameter int ROWS   = 254,
  parameter int COLS   = 254,
  parameter int RD_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
`ifdef MEDIAN_SCAN_PASSTHRU_EN
  input  logic                 passthru,
`endif
  median_scan_engine_if.master mem,
  output logic                 busy,
  output logic                 done
);

  // Chain holds every stage except the final write register.
  localparam int                CH_D     = RD_LAT + MED_LAT;
  localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(ROWS - 1);
  localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(COLS - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  state_e                   state_q, state_d;
  logic [ADDR_W-1:0]        row_q, row_d, col_q, col_d;
  logic                     rd_q, rd_d, busy_q, busy_d, done_q, done_d;
  chain_entry_t [CH_D-2:0]  chain_q;
  logic                     chain_busy_s, last_issue_s;
  logic                     wr_q;
  logic [ADDR_W-1:0]        addr_row_w_q, addr_col_w_q;
  logic [PIX_W-1:0]         median_s;
`ifdef MEDIAN_SCAN_PASSTHRU_EN
  logic                     pass_q;
`endif

  assign last_issue_s = (state_q == SCAN) && (row_q == ROW_LAST) && (col_q == COL_LAST);

  // Any window still in flight ahead of the write register.
  always_comb begin
    chain_busy_s = 1'b0;
    for (int i = 0; i < CH_D - 1; i++) begin
      chain_busy_s = chain_busy_s | chain_q[i].valid;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = SCAN;
        else       state_d = IDLE;
      end
      SCAN: begin
        if (last_issue_s) state_d = DRAIN;
        else              state_d = SCAN;
      end
      DRAIN: begin
        if (!chain_busy_s) state_d = DONE;
        else               state_d = DRAIN;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs and scan address generation (column-first raster).
  always_comb begin
    rd_d   = (state_d == SCAN);
    busy_d = (state_d == SCAN) || (state_d == DRAIN);
    done_d = (state_d == DONE);
    row_d  = row_q;
    col_d  = col_q;
    if ((state_q == IDLE) && start) begin
      row_d = '0;
      col_d = '0;
    end else if ((state_q == SCAN) && !last_issue_s) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = row_q + ADDR_ONE;
      end else begin
        col_d = col_q + ADDR_ONE;
      end
    end else begin
      row_d = row_q;
      col_d = col_q;
    end
  end

  // Output, address and valid/address chain registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q         <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      row_q        <= '0;
      col_q        <= '0;
      chain_q      <= '0;
      wr_q         <= 1'b0;
      addr_row_w_q <= '0;
      addr_col_w_q <= '0;
    end else begin
      rd_q       <= rd_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      row_q      <= row_d;
      col_q      <= col_d;
      chain_q[0] <= chain_entry_t'{valid: rd_q, row: row_q, col: col_q};
      for (int i = 1; i < CH_D - 1; i++) begin
        chain_q[i] <= chain_q[i-1];
      end
      wr_q <= chain_q[CH_D-2].valid;
      if (chain_q[CH_D-2].valid) begin
        addr_row_w_q <= chain_q[CH_D-2].row;
        addr_col_w_q <= chain_q[CH_D-2].col;
      end
    end
  end

`ifdef MEDIAN_SCAN_PASSTHRU_EN
  // Mode is latched with start and held for the whole frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      pass_q <= 1'b0;
    end else if ((state_q == IDLE) && start) begin
      pass_q <= passthru;
    end
  end
`endif

  median9_pipe u_pipe (
    .clk        (clk),
    .rst        (rst),
    .valid_i    (chain_q[RD_LAT-1].valid),
`ifdef MEDIAN_SCAN_PASSTHRU_EN
    .passthru_i (pass_q),
`endif
    .p1_i       (mem.sw_pixel_1),
    .p2_i       (mem.sw_pixel_2),
    .p3_i       (mem.sw_pixel_3),
    .p4_i       (mem.sw_pixel_4),
    .p5_i       (mem.sw_pixel_5),
    .p6_i       (mem.sw_pixel_6),
    .p7_i       (mem.sw_pixel_7),
    .p8_i       (mem.sw_pixel_8),
    .p9_i       (mem.sw_pixel_9),
    .median_o   (median_s)
  );

  assign mem.rd         = rd_q;
  assign mem.addr_row_r = row_q;
  assign mem.addr_col_r = col_q;
  assign mem.wr         = wr_q;
  assign mem.addr_row_w = addr_row_w_q;
  assign mem.addr_col_w = addr_col_w_q;
  assign mem.cl_pixel   = median_s;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule

// File: tb/tb_median_scan_engine.sv
// Directed bench for median_scan_engine on a 2x2 scan with a one-cycle memory model.
module tb_median_scan_engine;
  import median_scan_pkg::*;

  localparam int ROWS   = 2;
  localparam int COLS   = 2;
  localparam int RD_LAT = 1;
  localparam int LAT    = RD_LAT + 3;

  logic clk = 1'b0;
  logic rst, start, busy, done;
`ifdef MEDIAN_SCAN_PASSTHRU_EN
  logic passthru;
`endif

  median_scan_engine_if mif ();

  median_scan_engine #(.ROWS(ROWS), .COLS(COLS), .RD_LAT(RD_LAT)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
`ifdef MEDIAN_SCAN_PASSTHRU_EN
    .passthru (passthru),
`endif
    .mem      (mif),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  row;
    logic [7:0]  col;
    logic [7:0]  pix;
    logic [31:0] due;
  } exp_t;

  logic [7:0] win [0:3][0:8];
  logic [7:0] exp_med [0:3];
  exp_t       sb_q[$];
  int         cyc, total, bad, rd_idx, wr_cnt;
  bit         pt_mode;

  function automatic int midx(input logic [7:0] r, input logic [7:0] c);
    int idx;
    idx = int'(r) * COLS + int'(c);
    return (idx < ROWS * COLS) ? idx : 0;
  endfunction

  // Memory model: window contents appear one cycle after the read strobe.
  always @(posedge clk) begin
    if (mif.rd === 1'b1) begin
      mif.sw_pixel_1 <= win[midx(mif.addr_row_r, mif.addr_col_r)][0];
      mif.sw_pixel_2 <= win[midx(mif.addr_row_r, mif.addr_col_r)][1];
      mif.sw_pixel_3 <= win[midx(mif.addr_row_r, mif.addr_col_r)][2];
      mif.sw_pixel_4 <= win[midx(mif.addr_row_r, mif.addr_col_r)][3];
      mif.sw_pixel_5 <= win[midx(mif.addr_row_r, mif.addr_col_r)][4];
      mif.sw_pixel_6 <= win[midx(mif.addr_row_r, mif.addr_col_r)][5];
      mif.sw_pixel_7 <= win[midx(mif.addr_row_r, mif.addr_col_r)][6];
      mif.sw_pixel_8 <= win[midx(mif.addr_row_r, mif.addr_col_r)][7];
      mif.sw_pixel_9 <= win[midx(mif.addr_row_r, mif.addr_col_r)][8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // One cycle: sample at the falling edge, push issued reads, pop and compare writes.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (mif.rd === 1'b1) begin
      if (rd_idx >= ROWS * COLS) begin
        chk("rd_extra", 32'(mif.rd), 32'd0);
      end else begin
        chk("rd_row", 32'(mif.addr_row_r), 32'(rd_idx / COLS));
        chk("rd_col", 32'(mif.addr_col_r), 32'(rd_idx % COLS));
        e.row = 8'(rd_idx / COLS);
        e.col = 8'(rd_idx % COLS);
        e.pix = pt_mode ? win[rd_idx][4] : exp_med[rd_idx];
        e.due = 32'(cyc + LAT);
        sb_q.push_back(e);
        rd_idx++;
      end
    end
    if (mif.wr === 1'b1) begin
      wr_cnt++;
      if (sb_q.size() == 0) begin
        chk("wr_unexpected", 32'(mif.wr), 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("wr_row", 32'(mif.addr_row_w), 32'(e.row));
        chk("wr_col", 32'(mif.addr_col_w), 32'(e.col));
        chk("wr_pix", 32'(mif.cl_pixel), 32'(e.pix));
        chk("wr_lat", 32'(cyc), e.due);
      end
    end
  endtask

  // Full frame from a start pulse; optionally re-pulse start in SCAN and in DONE.
  task automatic run_frame(input bit repulse);
    tick();
    cyc    = 0;
    rd_idx = 0;
    wr_cnt = 0;
    start  = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      start = repulse && (c == 2 || c == 9);
      chk("rd",   32'(mif.rd), 32'(c >= 1 && c <= 4));
      chk("wr",   32'(mif.wr), 32'(c >= 5 && c <= 8));
      chk("busy", 32'(busy),   32'(c >= 1 && c <= 8));
      chk("done", 32'(done),   32'(c == 9));
    end
    chk("wr_count",   32'(wr_cnt), 32'(ROWS * COLS));
    chk("sb_left",    32'(sb_q.size()), 32'd0);
    chk("hold_pix",   32'(mif.cl_pixel), 32'(pt_mode ? win[3][4] : exp_med[3]));
    chk("hold_row_w", 32'(mif.addr_row_w), 32'(ROWS - 1));
    chk("hold_col_w", 32'(mif.addr_col_w), 32'(COLS - 1));
  endtask

  initial begin
    win[0] = '{8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    win[1] = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255};
    win[2] = '{8'h2A, 8'h2A, 8'h2A, 8'h2A, 8'h2A, 8'h2A, 8'h2A, 8'h2A, 8'h2A};
    win[3] = '{8'd1, 8'd200, 8'd3, 8'd50, 8'd4, 8'd90, 8'd7, 8'd60, 8'd8};
    exp_med = '{8'd5, 8'd255, 8'h2A, 8'd8};
    total   = 0;
    bad     = 0;
    cyc     = 0;
    rd_idx  = 0;
    wr_cnt  = 0;
    pt_mode = 1'b0;
    rst     = 1'b1;
    start   = 1'b0;
`ifdef MEDIAN_SCAN_PASSTHRU_EN
    passthru = 1'b0;
`endif

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_rd",   32'(mif.rd), 32'd0);
    chk("rst_wr",   32'(mif.wr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pix",  32'(mif.cl_pixel), 32'd0);
    rst = 1'b0;

    // Nominal frame.
    run_frame(1'b0);

    // Reset in SCAN cycle 3 aborts the frame.
    tick();
    cyc    = 0;
    rd_idx = 0;
    start  = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    sb_q.delete();
    tick();
    chk("abort_rd",    32'(mif.rd), 32'd0);
    chk("abort_row_r", 32'(mif.addr_row_r), 32'd0);
    chk("abort_col_r", 32'(mif.addr_col_r), 32'd0);
    chk("abort_wr",    32'(mif.wr), 32'd0);
    chk("abort_row_w", 32'(mif.addr_row_w), 32'd0);
    chk("abort_col_w", 32'(mif.addr_col_w), 32'd0);
    chk("abort_pix",   32'(mif.cl_pixel), 32'd0);
    chk("abort_busy",  32'(busy), 32'd0);
    chk("abort_done",  32'(done), 32'd0);
    rst    = 1'b0;
    rd_idx = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      chk("post_abort_wr",   32'(mif.wr), 32'd0);
      chk("post_abort_done", 32'(done), 32'd0);
      chk("post_abort_busy", 32'(busy), 32'd0);
    end

    // Rescan from (0,0) with ignored start pulses in SCAN and DONE.
    run_frame(1'b1);

`ifdef MEDIAN_SCAN_PASSTHRU_EN
    passthru = 1'b1;
    pt_mode  = 1'b1;
    run_frame(1'b0);
    passthru = 1'b0;
    pt_mode  = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/median_scan_engine.md
Name: median_scan_engine

Overview:
- Scan and compute stage that feeds the image `memory` block.
- Walks every 3x3 window of the padded image with one read per cycle, driving `rd` and `addr_row_r`/`addr_col_r`.
- Consumes `sw_pixel_1..9` and computes their median in a 3-stage pipeline.
- Returns each median as `cl_pixel` with `wr` and `addr_row_w`/`addr_col_w`, so `memory` stores the filtered image.

Parameters:
- ROWS, 254, number of window rows scanned (window top-left row 0..ROWS-1); range 1..254.
- COLS, 254, number of window columns scanned; range 1..254.
- RD_LAT, 1, cycles from address/`rd` issue to valid `sw_pixel_*` at `memory` outputs; range 1..4.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to begin a full-frame scan
- rd  out  1  read strobe to memory
- addr_row_r  out  8  window top-left row
- addr_col_r  out  8  window top-left column
- sw_pixel_1..sw_pixel_9  in  8 each  window pixels, row-major (1..3 top row, 4..6 middle, 7..9 bottom)
- wr  out  1  write strobe to memory
- addr_row_w  out  8  write row (equals the read row of that window)
- addr_col_w  out  8  write column
- cl_pixel  out  8  median result
- busy  out  1  high from the cycle after `start` is accepted until `done`
- done  out  1  one-cycle pulse after the last write

Behaviour:
- Reset (sync, high): state IDLE; all outputs 0; valid/address shift chain cleared.
  - Reset mid-scan aborts immediately: no further `wr`, no `done`.
- FSM IDLE -> SCAN -> DRAIN -> DONE -> IDLE.
  - IDLE: `start`=1 -> SCAN next cycle with address (0,0); `busy`=1.
  - SCAN: `rd`=1 every cycle; addresses advance column-first.
    - col wraps COLS-1 -> 0 and row increments.
    - Issuing (ROWS-1, COLS-1) -> DRAIN next cycle; `rd`=0 from then.
  - DRAIN: wait until the valid chain is empty (RD_LAT+3 cycles after the last issue).
  - DONE: `done`=1, `busy`=0 for one cycle -> IDLE.
- `start` outside IDLE is ignored. `start` in the DONE cycle is ignored; a new scan needs `start` in IDLE.
- Exactly ROWS*COLS reads and ROWS*COLS writes per frame. Order is identical; no gaps while SCAN runs.
- Valid/address chain: RD_LAT+3 deep. Entry = (valid, row, col) captured at issue.
  - Read data is sampled when the entry reaches depth RD_LAT.
- Median pipeline (sub-module), each stage registered:
  - S1: sort each row triple -> (min, med, max) per row.
  - S2: lo = max of 3 mins; mid = median of 3 meds; hi = min of 3 maxes.
  - S3: cl_pixel = median(lo, mid, hi).
- Latency: address issued in cycle k -> `wr`/`addr_*_w`/`cl_pixel` valid in cycle k+RD_LAT+3.
- Comparisons unsigned 8-bit; no arithmetic, no overflow.
- `cl_pixel` and `addr_*_w` hold their last value when `wr`=0.
- Throughput: 1 window/cycle. First-to-last cycle count: ROWS*COLS + RD_LAT + 3 + 1.

Optional Feature:
- Macro: MEDIAN_SCAN_PASSTHRU_EN.
- Defined:
  - Adds input port `passthru` (1 bit), sampled in IDLE on the `start` cycle and held for the frame.
  - When set, `cl_pixel` = `sw_pixel_5` delayed through the same 3 stages; latency and addresses unchanged.
- Not defined: no port; median always.

Decomposition:
- Package `median_scan_pkg` holds:
  - PIX_W=8, ADDR_W=8, MED_LAT=3.
  - State enum (IDLE, SCAN, DRAIN, DONE).
  - Chain entry struct (valid, row, col).
- Sub-module `median9_pipe`: 9x8-bit in, 8-bit out, MED_LAT registered stages. Carries the passthru path when the macro is enabled. Synchronous clear on `rst`.

Test Plan:
- ROWS=COLS=2, RD_LAT=1, `start` at cycle 0 with a memory model:
  - `rd` high cycles 1-4.
  - Addresses (0,0),(0,1),(1,0),(1,1).
  - `wr` high cycles 5-8 with the same addresses.
  - `done` at cycle 9; `busy` cycles 1-8.
- Window 9,8,7,6,5,4,3,2,1 -> `cl_pixel`=5.
- Window 0,0,0,0,255,255,255,255,255 -> 255.
- Window of all 0x2A -> 0x2A.
- Window 1,200,3,50,4,90,7,60,8 -> 8.
- `rst` asserted during SCAN cycle 3 -> next cycle all outputs 0, no `wr` afterwards, no `done`. A subsequent `start` rescans from (0,0).
- `start` re-pulsed during SCAN and during DONE -> ignored, exactly 4 writes.
- With MEDIAN_SCAN_PASSTHRU_EN and `passthru`=1 -> `cl_pixel`=`sw_pixel_5`, same timing.
